// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between the WB pipeline path and a
// long-latency unit whose result waits in a one-entry buffer for a free slot.
module wb_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipeWeW_i,
  input  logic [4:0]  pipeRdW_i,
  input  logic [31:0] pipeDataW_i,
  input  logic        lluValid_i,
  output logic        lluReady_o,
  input  logic [4:0]  lluRd_i,
  input  logic [31:0] lluData_i,
  output logic        rfWe_o,
  output logic [4:0]  rfRd_o,
  output logic [31:0] rfData_o,
  output logic        stallReq_o,
  output logic        lluDrop_o,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FORCE = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(STARVE_LIMIT - 1);

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [4:0]  held_rd_q, held_rd_d;
  logic [31:0] held_data_q, held_data_d;
  logic        rf_we_d, drop_d;
  logic [4:0]  rf_rd_d;
  logic [31:0] rf_data_d;

  logic slot_busy, holding, grant, waw_hit, llu_accept;

  // LLU handshake: a result transfers on a cycle where lluValid_i and
  // lluReady_o are both high; lluValid_i may not depend on lluReady_o.
  assign lluReady_o = (state_q == IDLE);
  assign stallReq_o = (state_q == FORCE);
  assign dbg_state  = state_q;

  assign slot_busy  = pipeWeW_i && (pipeRdW_i != 5'd0);
  assign holding    = (state_q == HOLD) || (state_q == FORCE);
  assign grant      = holding && !slot_busy;
  assign waw_hit    = holding && slot_busy && (pipeRdW_i == held_rd_q);
  assign llu_accept = lluValid_i && lluReady_o && (lluRd_i != 5'd0);

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    held_rd_d   = held_rd_q;
    held_data_d = held_data_q;
    rf_we_d     = 1'b0;
    rf_rd_d     = pipeRdW_i;
    rf_data_d   = pipeDataW_i;
    drop_d      = 1'b0;

    if (slot_busy) begin
      rf_we_d = 1'b1;
    end else if (grant) begin
      rf_we_d   = 1'b1;
      rf_rd_d   = held_rd_q;
      rf_data_d = held_data_q;
    end

    case (state_q)
      IDLE: begin
        if (llu_accept) begin
          state_d     = HOLD;
          wait_cnt_d  = 4'd0;
          held_rd_d   = lluRd_i;
          held_data_d = lluData_i;
        end
      end
      HOLD: begin
        if (grant) begin
          state_d = IDLE;
        end else if (waw_hit) begin
          state_d = IDLE;
          drop_d  = 1'b1;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = FORCE;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      FORCE: begin
        if (grant) begin
          state_d = IDLE;
        end else if (waw_hit) begin
          state_d = IDLE;
          drop_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= 4'd0;
      held_rd_q   <= 5'd0;
      held_data_q <= 32'd0;
      rfWe_o      <= 1'b0;
      rfRd_o      <= 5'd0;
      rfData_o    <= 32'd0;
      lluDrop_o   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      held_rd_q   <= held_rd_d;
      held_data_q <= held_data_d;
      rfWe_o      <= rf_we_d;
      rfRd_o      <= rf_rd_d;
      rfData_o    <= rf_data_d;
      lluDrop_o   <= drop_d;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, LLU grant, starvation stall,
// WAW drop, x0 handling and reset while a stall is requested.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipeWeW_i;
  logic [4:0]  pipeRdW_i;
  logic [31:0] pipeDataW_i;
  logic        lluValid_i;
  logic        lluReady_o;
  logic [4:0]  lluRd_i;
  logic [31:0] lluData_i;
  logic        rfWe_o;
  logic [4:0]  rfRd_o;
  logic [31:0] rfData_o;
  logic        stallReq_o;
  logic        lluDrop_o;
  logic [1:0]  dbg_state;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .pipeWeW_i  (pipeWeW_i),
    .pipeRdW_i  (pipeRdW_i),
    .pipeDataW_i(pipeDataW_i),
    .lluValid_i (lluValid_i),
    .lluReady_o (lluReady_o),
    .lluRd_i    (lluRd_i),
    .lluData_i  (lluData_i),
    .rfWe_o     (rfWe_o),
    .rfRd_o     (rfRd_o),
    .rfData_o   (rfData_o),
    .stallReq_o (stallReq_o),
    .lluDrop_o  (lluDrop_o),
    .dbg_state  (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // checking
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt = chk_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else begin
      fail_cnt = fail_cnt + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rf(input string tag, input logic we, input logic [4:0] rd,
                        input logic [31:0] data);
    chk({tag, "_we"}, {31'd0, rfWe_o}, {31'd0, we});
    if (we) begin
      chk({tag, "_rd"}, {27'd0, rfRd_o}, {27'd0, rd});
      chk({tag, "_data"}, rfData_o, data);
    end
  endtask

  // driver tasks: advance one edge, then sample 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
    chk("stall_ready_excl", {31'd0, stallReq_o & lluReady_o}, 32'd0);
  endtask

  task automatic drive_pipe(input logic we, input logic [4:0] rd, input logic [31:0] data);
    pipeWeW_i   = we;
    pipeRdW_i   = rd;
    pipeDataW_i = data;
  endtask

  task automatic drive_llu(input logic v, input logic [4:0] rd, input logic [31:0] data);
    lluValid_i = v;
    lluRd_i    = rd;
    lluData_i  = data;
  endtask

  initial begin
    // reset with all inputs active
    reset = 1'b1;
    drive_pipe(1'b1, 5'd3, 32'h1234_5678);
    drive_llu(1'b1, 5'd5, 32'hCAFE_F00D);
    step();
    step();
    chk("rst_rf_we", {31'd0, rfWe_o}, 32'd0);
    chk("rst_rf_rd", {27'd0, rfRd_o}, 32'd0);
    chk("rst_rf_data", rfData_o, 32'd0);
    chk("rst_stall", {31'd0, stallReq_o}, 32'd0);
    chk("rst_drop", {31'd0, lluDrop_o}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    reset = 1'b0;
    drive_pipe(1'b0, 5'd0, 32'd0);
    drive_llu(1'b0, 5'd0, 32'd0);
    #1;
    chk("post_rst_ready", {31'd0, lluReady_o}, 32'd1);

    // free-slot LLU result lands two cycles after the handshake
    drive_llu(1'b1, 5'd5, 32'hDEAD_BEEF);
    step();
    drive_llu(1'b0, 5'd0, 32'd0);
    chk("free_t1_ready", {31'd0, lluReady_o}, 32'd0);
    chk_rf("free_t1", 1'b0, 5'd0, 32'd0);
    step();
    chk_rf("free_t2", 1'b1, 5'd5, 32'hDEAD_BEEF);
    chk("free_t2_ready", {31'd0, lluReady_o}, 32'd1);
    chk("free_t2_stall", {31'd0, stallReq_o}, 32'd0);
    step();
    chk_rf("free_t3", 1'b0, 5'd0, 32'd0);

    // starvation: busy pipeline writing rd=3 every cycle after handshake rd=7
    drive_llu(1'b1, 5'd7, 32'h0000_0077);
    drive_pipe(1'b1, 5'd3, 32'h300);
    step();
    drive_llu(1'b0, 5'd0, 32'd0);
    for (int k = 1; k <= 6; k++) begin
      chk_rf("starve_pipe", 1'b1, 5'd3, 32'h300 + 32'(k - 1));
      chk("starve_stall", {31'd0, stallReq_o}, (k >= 5) ? 32'd1 : 32'd0);
      drive_pipe(1'b1, 5'd3, 32'h300 + 32'(k));
      step();
    end
    chk_rf("starve_t7", 1'b1, 5'd3, 32'h306);
    chk("starve_t7_stall", {31'd0, stallReq_o}, 32'd1);
    drive_pipe(1'b0, 5'd0, 32'd0);
    step();
    chk_rf("starve_grant", 1'b1, 5'd7, 32'h77);
    chk("starve_t8_stall", {31'd0, stallReq_o}, 32'd0);
    chk("starve_t8_ready", {31'd0, lluReady_o}, 32'd1);

    // WAW: held rd=9 superseded by a younger pipeline write to rd=9
    drive_llu(1'b1, 5'd9, 32'h0000_0BAD);
    step();
    drive_llu(1'b0, 5'd0, 32'd0);
    drive_pipe(1'b1, 5'd2, 32'h22);
    step();
    chk_rf("waw_other", 1'b1, 5'd2, 32'h22);
    chk("waw_hold_ready", {31'd0, lluReady_o}, 32'd0);
    drive_pipe(1'b1, 5'd9, 32'h11);
    step();
    chk_rf("waw_pipe", 1'b1, 5'd9, 32'h11);
    chk("waw_drop", {31'd0, lluDrop_o}, 32'd1);
    chk("waw_ready", {31'd0, lluReady_o}, 32'd1);
    drive_pipe(1'b0, 5'd0, 32'd0);
    step();
    chk_rf("waw_after", 1'b0, 5'd0, 32'd0);
    chk("waw_drop_end", {31'd0, lluDrop_o}, 32'd0);
    step();
    chk_rf("waw_after2", 1'b0, 5'd0, 32'd0);

    // x0 handling
    drive_llu(1'b1, 5'd0, 32'h55);
    step();
    drive_llu(1'b0, 5'd0, 32'd0);
    chk("x0_llu_ready", {31'd0, lluReady_o}, 32'd1);
    chk_rf("x0_llu_t1", 1'b0, 5'd0, 32'd0);
    step();
    chk_rf("x0_llu_t2", 1'b0, 5'd0, 32'd0);
    drive_llu(1'b1, 5'd4, 32'h44);
    step();
    drive_llu(1'b0, 5'd0, 32'd0);
    chk("x0_hold_ready", {31'd0, lluReady_o}, 32'd0);
    drive_pipe(1'b1, 5'd0, 32'h99);
    step();
    chk_rf("x0_pipe_free", 1'b1, 5'd4, 32'h44);
    drive_pipe(1'b0, 5'd0, 32'd0);
    step();
    chk_rf("x0_after", 1'b0, 5'd0, 32'd0);

    // reset while FORCE is active
    drive_llu(1'b1, 5'd6, 32'h66);
    drive_pipe(1'b1, 5'd1, 32'h10);
    step();
    drive_llu(1'b0, 5'd0, 32'd0);
    repeat (4) step();
    chk("rf_stall_set", {31'd0, stallReq_o}, 32'd1);
    reset = 1'b1;
    drive_pipe(1'b0, 5'd0, 32'd0);
    step();
    chk("rf_stall_clr", {31'd0, stallReq_o}, 32'd0);
    chk_rf("rf_reset", 1'b0, 5'd0, 32'd0);
    chk("rf_drop", {31'd0, lluDrop_o}, 32'd0);
    reset = 1'b0;
    step();
    chk_rf("rf_never_written", 1'b0, 5'd0, 32'd0);
    chk("rf_ready", {31'd0, lluReady_o}, 32'd1);
    step();
    chk_rf("rf_never_written2", 1'b0, 5'd0, 32'd0);

    // report
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline writeback path and a long-latency unit (LLU: multi-cycle mul/div) that returns results out of band. Sits between the WB stage outputs and the RF write port in ID. Pipeline writes always win. An LLU result is held in a one-entry buffer until a free write slot exists. A starvation counter requests a pipeline stall to force a free slot.

## Interface
Parameters:
- STARVE_LIMIT, 4: cycles a held LLU result may wait in HOLD before a stall is requested (legal range 1..15).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- pipeWeW_i  in  1  pipeline WB write enable.
- pipeRdW_i  in  5  pipeline WB destination register.
- pipeDataW_i  in  32  pipeline WB data.
- lluValid_i  in  1  LLU result valid.
- lluReady_o  out  1  arbiter can accept an LLU result.
- lluRd_i  in  5  LLU destination register.
- lluData_i  in  32  LLU result data.
- rfWe_o  out  1  RF write enable (registered).
- rfRd_o  out  5  RF write index (registered).
- rfData_o  out  32  RF write data (registered).
- stallReq_o  out  1  request to the hazard unit to freeze the front end so a bubble reaches WB.
- lluDrop_o  out  1  one-cycle pulse: held LLU result discarded due to WAW.

## Operation
- Pipeline slot is **busy** when pipeWeW_i=1 and pipeRdW_i≠0. Otherwise it is **free**.
- State machine: IDLE (no held entry), HOLD (entry held), FORCE (entry held, stall active). Holding register fields: heldRd, heldData. Wait counter: waitCnt, 4 bits.
- lluReady_o = 1 only in IDLE. A handshake (lluValid_i & lluReady_o) with lluRd_i≠0 latches lluRd_i and lluData_i and moves IDLE→HOLD with waitCnt=0. A handshake with lluRd_i=0 is accepted and discarded, and the state stays IDLE.
- Output selection each cycle, registered at the edge:
  - If the pipeline slot is busy: rf outputs take the pipeline write.
  - Else, if in HOLD or FORCE: rf outputs take the held entry (grant). The state goes to IDLE.
  - Else: rfWe_o=0; rfRd_o and rfData_o take the pipeline values.
- In HOLD without grant: waitCnt increments. When waitCnt reaches STARVE_LIMIT-1 and there is no grant, the next state is FORCE.
- In FORCE: stallReq_o=1, decoded from the registered state. The arbiter stays in FORCE until the pipeline slot is free, then grants and goes to IDLE.
- WAW rule: if the state is HOLD or FORCE, the slot is busy, and pipeRdW_i=heldRd, the held entry is discarded (the younger pipeline write wins). The pipeline write proceeds, the state goes to IDLE, and lluDrop_o=1 next cycle.
- Reset: all outputs 0, state IDLE, waitCnt 0, heldRd 0, heldData 0. Asserting reset mid-HOLD or mid-FORCE discards the held entry without a drop pulse.

## Timing
- Pipeline write at cycle t appears on rf outputs at t+1. The latency is a fixed 1 cycle, independent of LLU activity.
- LLU handshake at t: held at t+1. If the slot is free at t+1, the result is on rf outputs at t+2, and lluReady_o=1 again at t+2.
- There is no same-cycle pass-through. Minimum LLU issue interval is 2 cycles.
- With continuous busy slots after handshake at t: FORCE is entered at t+1+STARVE_LIMIT, and stallReq_o=1 from that cycle.
- stallReq_o drops the cycle after the grant edge. The grant lands on rf outputs in that same cycle.
- lluDrop_o is registered, high for exactly one cycle.
- stallReq_o and lluReady_o are never both 1.

## Test plan
- **Reset:** drive reset=1 for 2 cycles with all inputs active → all outputs 0. lluReady_o=1 in the first cycle after reset deasserts.
- **Free-slot LLU:** lluValid_i=1, lluRd_i=5, lluData_i=0xDEADBEEF at t, with pipeWeW_i=0 → at t+2: rfWe_o=1, rfRd_o=5, rfData_o=0xDEADBEEF, lluReady_o=1. stallReq_o stays 0.
- **Starvation:** STARVE_LIMIT=4. Handshake rd=7 at t, then pipeline busy writing rd=3 every cycle.
  - Required: rf outputs carry rd=3 each cycle, and stallReq_o=1 from t+5.
  - Drop pipeWeW_i at t+7 → rf shows rd=7 at t+8, and stallReq_o=0 at t+8.
- **WAW drop:** hold rd=9, then pipeline writes rd=9 with data 0x11 → rf shows rd=9/0x11 once. lluDrop_o pulses once. The held value is never written, and lluReady_o returns to 1.
- **x0 handling:** LLU result with rd=0 → accepted, no RF write, and the state stays IDLE. Pipeline write with rd=0 while holding rd=4 → the slot counts as free, and rd=4 is written next cycle.
- **Reset mid-FORCE:** assert reset while stallReq_o=1 → next cycle stallReq_o=0, rfWe_o=0, lluDrop_o=0, and the held entry is never written.
